// File: rtl/reg_shift_sequencer_pkg.sv
// Shared constants for the serial shift sequencer: shift-type and FSM encodings,
// widths, and the accept-time decode of a request into a step count or a direct result.
package reg_shift_sequencer_pkg;
   localparam int DATA_W = 32;
   localparam int AMT_W  = 8;
   localparam int CNT_W  = 6;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   typedef struct packed {
      logic [CNT_W-1:0]  n;
      logic [DATA_W-1:0] res;
      logic              carry;
   } decode_t;

   // n == 0 means res/carry are final; otherwise res/carry are don't-care and n steps follow.
   function automatic decode_t decode_req(input logic [DATA_W-1:0] rm, input logic [AMT_W-1:0] rs,
                                          input shift_t t, input logic c);
      decode_t d;
      d.n     = '0;
      d.res   = rm;
      d.carry = c;
      if (rs != '0) begin
         unique case (t)
            SH_LSL, SH_LSR: begin
               if (rs > AMT_W'(DATA_W)) begin
                  d.res   = '0;
                  d.carry = 1'b0;
               end else begin
                  d.n = rs[CNT_W-1:0];
               end
            end
            SH_ASR: d.n = (rs >= AMT_W'(DATA_W)) ? CNT_W'(DATA_W) : rs[CNT_W-1:0];
            SH_ROR: begin
               if (rs[4:0] == 5'd0) d.carry = rm[DATA_W-1];
               else                 d.n     = {1'b0, rs[4:0]};
            end
         endcase
      end
      return d;
   endfunction
endpackage

// File: rtl/reg_shift_sequencer_if.sv
// Request/response bundle between a pipeline stage (master) and the shift sequencer (slave).
interface reg_shift_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int AMT_W  = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] val_rm;
   logic [AMT_W-1:0]  val_rs;
   logic [1:0]        shift_type;
   logic              c_in;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] val2_out;
   logic              carry_out;
   logic              busy;

   modport master (
      output req_valid, val_rm, val_rs, shift_type, c_in, resp_ready,
      input  req_ready, resp_valid, val2_out, carry_out, busy
   );

   modport slave (
      input  req_valid, val_rm, val_rs, shift_type, c_in, resp_ready,
      output req_ready, resp_valid, val2_out, carry_out, busy
   );
endinterface

// File: rtl/reg_shift_sequencer_step.sv
// One-bit shift step of the latched type; combinational, reused every SHIFT cycle.
module shift_step_unit
   import reg_shift_sequencer_pkg::*;
(
   input  logic [DATA_W-1:0] i_value,
   input  shift_t            i_type,
   output logic [DATA_W-1:0] o_value,
   output logic              o_carry
);
   always_comb begin
      o_value = i_value;
      o_carry = i_value[0];
      unique case (i_type)
         SH_LSL: begin
            o_value = {i_value[DATA_W-2:0], 1'b0};
            o_carry = i_value[DATA_W-1];
         end
         SH_LSR: o_value = {1'b0, i_value[DATA_W-1:1]};
         SH_ASR: o_value = {i_value[DATA_W-1], i_value[DATA_W-1:1]};
         SH_ROR: o_value = {i_value[0], i_value[DATA_W-1:1]};
      endcase
   end
endmodule

// File: rtl/reg_shift_sequencer.sv
// Multi-cycle barrel-shift replacement: one bit per cycle, IDLE/SHIFT/DONE handshake FSM.
// Optional SHIFT_SEQ_FLUSH_EN adds a flush input that abandons an in-flight operation.
module reg_shift_sequencer #(
   parameter int DATA_W = reg_shift_sequencer_pkg::DATA_W,
   parameter int AMT_W  = reg_shift_sequencer_pkg::AMT_W
) (
   input  logic clk,
   input  logic rst,
`ifdef SHIFT_SEQ_FLUSH_EN
   input  logic flush,
`endif
   reg_shift_sequencer_if.slave bus
);
   import reg_shift_sequencer_pkg::*;

   if (DATA_W != 32 || AMT_W != 8) begin : g_bad_cfg
      $error("reg_shift_sequencer supports only DATA_W=32, AMT_W=8");
   end

   state_t            r_state;
   shift_t            r_type;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_work;
   logic [DATA_W-1:0] r_val2;
   logic              r_carry;
   logic              r_req_ready;
   logic              r_resp_valid;
   logic              r_busy;

   decode_t           w_dec;
   logic [DATA_W-1:0] w_step_val;
   logic              w_step_carry;

   always_comb w_dec = decode_req(bus.val_rm, bus.val_rs, shift_t'(bus.shift_type), bus.c_in);

   shift_step_unit u_step (
      .i_value (r_work),
      .i_type  (r_type),
      .o_value (w_step_val),
      .o_carry (w_step_carry)
   );

   // Output registers are loaded only on entry to DONE so they read zero at all other times.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_type       <= SH_LSL;
         r_cnt        <= '0;
         r_work       <= '0;
         r_val2       <= '0;
         r_carry      <= 1'b0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_busy       <= 1'b0;
      end
`ifdef SHIFT_SEQ_FLUSH_EN
      else if (flush && r_state != ST_IDLE) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_val2       <= '0;
         r_carry      <= 1'b0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_busy       <= 1'b0;
      end
`endif
      else begin
         unique case (r_state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  r_type      <= shift_t'(bus.shift_type);
                  r_work      <= bus.val_rm;
                  r_cnt       <= w_dec.n;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (w_dec.n == '0) begin
                     r_state      <= ST_DONE;
                     r_val2       <= w_dec.res;
                     r_carry      <= w_dec.carry;
                     r_resp_valid <= 1'b1;
                  end else begin
                     r_state <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               r_work <= w_step_val;
               r_cnt  <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_state      <= ST_DONE;
                  r_val2       <= w_step_val;
                  r_carry      <= w_step_carry;
                  r_resp_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.resp_ready) begin
                  r_state      <= ST_IDLE;
                  r_val2       <= '0;
                  r_carry      <= 1'b0;
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_busy       <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.val2_out   = r_val2;
   assign bus.carry_out  = r_carry;
   assign bus.busy       = r_busy;
endmodule

// File: tb/tb_reg_shift_sequencer.sv
// Bench for reg_shift_sequencer: directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for backpressure, reset and flush.
module tb_reg_shift_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef SHIFT_SEQ_FLUSH_EN
   logic flush = 1'b0;
`endif
   int   checks = 0;
   int   errors = 0;

   reg_shift_sequencer_if #(.DATA_W(32), .AMT_W(8)) bus ();

   reg_shift_sequencer #(.DATA_W(32), .AMT_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef SHIFT_SEQ_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rm;
      logic [7:0]  rs;
      logic [1:0]  t;
      logic        c;
      logic [31:0] res;
      logic        co;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic shifts with one extra guard bit catching the carry.
   task automatic model(input logic [31:0] rm, input logic [7:0] rs, input logic [1:0] t,
                        input logic c, output logic [31:0] res, output logic co, output int lat);
      logic [63:0]        u;
      logic signed [63:0] s;
      int                 a;
      res = rm; co = c; lat = 1;
      a = int'(rs);
      if (a != 0) begin
         case (t)
            2'b00: if (a > 32) begin res = 0; co = 0; end
                   else begin u = {32'b0, rm} << a; res = u[31:0]; co = u[32]; lat = a + 1; end
            2'b01: if (a > 32) begin res = 0; co = 0; end
                   else begin u = {31'b0, rm, 1'b0} >> a; res = u[32:1]; co = u[0]; lat = a + 1; end
            2'b10: begin
               if (a > 32) a = 32;
               s = {{31{rm[31]}}, rm, 1'b0};
               s = s >>> a;
               res = s[32:1]; co = s[0]; lat = a + 1;
            end
            default: begin
               a = a % 32;
               if (a == 0) co = rm[31];
               else begin res = (rm >> a) | (rm << (32 - a)); co = res[31]; lat = a + 1; end
            end
         endcase
      end
   endtask

   // Called at #1 after a rising edge with the block idle.
   task automatic run_op(input logic [31:0] rm, input logic [7:0] rs, input logic [1:0] t,
                         input logic c, input logic [31:0] eres, input logic eco, input int elat,
                         input int hold, input string tag);
      int lat;
      bit got;
      chk({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1; bus.val_rm = rm; bus.val_rs = rs; bus.shift_type = t; bus.c_in = c;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 1; got = 0;
      while (!got && lat <= 40) begin
         if (bus.resp_valid) got = 1;
         else begin
            if (bus.val2_out !== 0 || bus.carry_out !== 0)
               chk({tag, " idle outputs zero"}, {bus.carry_out, bus.val2_out}, 64'd0);
            @(posedge clk); #1;
            lat++;
         end
      end
      chk({tag, " latency"}, 64'(lat), 64'(elat));
      repeat (hold) begin @(posedge clk); #1; end
      chk({tag, " val2_out"}, 64'(bus.val2_out), 64'(eres));
      chk({tag, " carry_out"}, 64'(bus.carry_out), 64'(eco));
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      chk({tag, " post resp_valid"}, {bus.resp_valid, bus.req_ready, bus.busy}, 64'b010);
   endtask

   task automatic watch_no_resp(input int cycles, input string tag);
      int seen = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (bus.resp_valid) seen++;
      end
      chk({tag, " no response"}, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [31:0] rm, eres;
      logic [7:0]  rs;
      logic [1:0]  t;
      logic        c, eco;
      int          elat;

      vecs[0] = '{32'h00000001,   4, 2'b00, 1'b0, 32'h00000010, 1'b0,  5};
      vecs[1] = '{32'h80000000,  40, 2'b10, 1'b0, 32'hFFFFFFFF, 1'b1, 33};
      vecs[2] = '{32'hFFFFFFFF,  33, 2'b01, 1'b1, 32'h00000000, 1'b0,  1};
      vecs[3] = '{32'h000000F1,   4, 2'b11, 1'b0, 32'h1000000F, 1'b0,  5};
      vecs[4] = '{32'h80000001,  32, 2'b11, 1'b0, 32'h80000001, 1'b1,  1};
      vecs[5] = '{32'hABCD1234,   0, 2'b00, 1'b1, 32'hABCD1234, 1'b1,  1};
      vecs[6] = '{32'h00000003,  32, 2'b00, 1'b0, 32'h00000000, 1'b1, 33};
      vecs[7] = '{32'h80000000,  32, 2'b01, 1'b0, 32'h00000000, 1'b1, 33};
      vecs[8] = '{32'h12345678,  36, 2'b11, 1'b0, 32'h81234567, 1'b1,  5};
      vecs[9] = '{32'h80000000,   1, 2'b01, 1'b1, 32'h40000000, 1'b0,  2};

      bus.req_valid = 0; bus.resp_ready = 0; bus.val_rm = 0; bus.val_rs = 0;
      bus.shift_type = 0; bus.c_in = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset state", {bus.req_ready, bus.resp_valid, bus.busy, bus.carry_out, bus.val2_out},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i])
         run_op(vecs[i].rm, vecs[i].rs, vecs[i].t, vecs[i].c, vecs[i].res, vecs[i].co,
                vecs[i].lat, i % 3, $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         rm = $urandom;
         rs = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
         t  = 2'($urandom_range(0, 3));
         c  = 1'($urandom_range(0, 1));
         model(rm, rs, t, c, eres, eco, elat);
         run_op(rm, rs, t, c, eres, eco, elat, $urandom_range(0, 2), $sformatf("rand%0d", i));
      end

      // Backpressure: DONE held with a competing request pending
      bus.req_valid = 1; bus.val_rm = 32'h00000001; bus.val_rs = 2; bus.shift_type = 2'b00; bus.c_in = 0;
      @(posedge clk); #1;
      bus.val_rm = 32'h00000080; bus.val_rs = 0; bus.shift_type = 2'b01; bus.c_in = 1;
      repeat (2) begin @(posedge clk); #1; end
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp hold%0d", k), {bus.resp_valid, bus.req_ready, bus.carry_out, bus.val2_out},
             {1'b1, 1'b0, 1'b0, 32'h00000004});
         @(posedge clk); #1;
      end
      bus.resp_ready = 1;
      @(posedge clk); #1;
      bus.resp_ready = 0;
      chk("bp back to idle", {bus.resp_valid, bus.req_ready}, 64'b01);
      @(posedge clk); #1;
      bus.req_valid = 0;
      chk("bp second op", {bus.resp_valid, bus.carry_out, bus.val2_out}, {1'b1, 1'b1, 32'h00000080});
      bus.resp_ready = 1;
      @(posedge clk); #1;
      bus.resp_ready = 0;

      // Reset in the 5th SHIFT cycle of a 20-step LSL
      bus.req_valid = 1; bus.val_rm = 32'h00000001; bus.val_rs = 20; bus.shift_type = 2'b00; bus.c_in = 0;
      @(posedge clk); #1;
      bus.req_valid = 0;
      chk("rst busy in shift", 64'(bus.busy), 64'd1);
      repeat (4) begin @(posedge clk); #1; end
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("rst mid-shift", {bus.req_ready, bus.resp_valid, bus.busy, bus.carry_out, bus.val2_out},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
      watch_no_resp(30, "rst");
      run_op(32'h00000001, 4, 2'b00, 0, 32'h00000010, 0, 5, 0, "after rst");

`ifdef SHIFT_SEQ_FLUSH_EN
      bus.req_valid = 1; bus.val_rm = 32'h00000001; bus.val_rs = 20; bus.shift_type = 2'b00;
      @(posedge clk); #1;
      bus.req_valid = 0;
      repeat (4) begin @(posedge clk); #1; end
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      chk("flush mid-shift", {bus.req_ready, bus.resp_valid, bus.busy, bus.val2_out},
          {1'b1, 1'b0, 1'b0, 32'h0});
      watch_no_resp(30, "flush");
      // Flush while idle must not block an accept
      flush = 1; bus.req_valid = 1; bus.val_rm = 32'h00000001; bus.val_rs = 3; bus.shift_type = 2'b00;
      @(posedge clk); #1;
      flush = 0; bus.req_valid = 0;
      chk("flush idle accept", 64'(bus.busy), 64'd1);
      repeat (3) begin @(posedge clk); #1; end
      chk("flush idle result", {bus.resp_valid, bus.val2_out}, {1'b1, 32'h00000008});
      bus.resp_ready = 1;
      @(posedge clk); #1;
      bus.resp_ready = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
